// File: rtl/fighter_pkg.sv
// Shared fighter definitions: motion-state encoding and default arena geometry.
// Reused by the motion block, the attack FSM and the sprite renderer.
package fighter_pkg;

  typedef enum logic [1:0] {
    StGround = 2'd0,
    StAir    = 2'd1,
    StKnock  = 2'd2
  } fighter_state_e;

  localparam int unsigned MIN_X    = 40;
  localparam int unsigned MAX_X    = 600;
  localparam int unsigned GROUND_Y = 400;

endpackage

// File: rtl/fighter_motion_if.sv
// Intent and position bundle between the input/attack controller, the motion block,
// and its consumers (sprite renderer, hit detector).
interface fighter_motion_if #(
  parameter int unsigned POS_WIDTH = 10
);
  logic                 SCEN;
  logic                 move_enable;
  logic                 move_left;
  logic                 move_right;
  logic                 jump;
  logic                 hit;
  logic                 hit_from_right;
  logic [POS_WIDTH-1:0] opponent_x;
  logic [POS_WIDTH-1:0] pos_x;
  logic [POS_WIDTH-1:0] pos_y;
  logic                 facing_right;
  logic [1:0]           state;
  logic                 move_active;
  logic                 landed;

  modport master (
    output SCEN, move_enable, move_left, move_right, jump, hit, hit_from_right, opponent_x,
    input  pos_x, pos_y, facing_right, state, move_active, landed
  );

  modport slave (
    input  SCEN, move_enable, move_left, move_right, jump, hit, hit_from_right, opponent_x,
    output pos_x, pos_y, facing_right, state, move_active, landed
  );
endinterface

// File: rtl/axis_clamp.sv
// Combinational clamp of a signed axis candidate to inclusive limits.
// hit_wall_o flags a candidate that reaches or passes either limit.
module axis_clamp #(
  parameter int unsigned W = 12
) (
  input  logic signed [W-1:0] val_i,
  input  logic signed [W-1:0] lo_i,
  input  logic signed [W-1:0] hi_i,
  output logic signed [W-1:0] val_o,
  output logic                hit_wall_o
);
  always_comb begin
    val_o      = val_i;
    hit_wall_o = 1'b0;
    if (val_i <= lo_i) begin
      val_o      = lo_i;
      hit_wall_o = 1'b1;
    end else if (val_i >= hi_i) begin
      val_o      = hi_i;
      hit_wall_o = 1'b1;
    end
  end
endmodule

// File: rtl/fighter_motion.sv
// Per-frame fighter position controller: walking, gravity jump and hit knockback,
// clamped to the arena walls and to a minimum body gap from the opponent.
module fighter_motion
  import fighter_pkg::*;
#(
  parameter int unsigned POS_WIDTH    = 10,
  parameter int unsigned GROUND_Y     = fighter_pkg::GROUND_Y,
  parameter int unsigned START_X      = 80,
  parameter bit          START_FACE_R = 1'b1,
  parameter int unsigned MIN_X        = fighter_pkg::MIN_X,
  parameter int unsigned MAX_X        = fighter_pkg::MAX_X,
  parameter int unsigned WALK_SPEED   = 2,
  parameter int unsigned JUMP_VEL     = 7,
  parameter int unsigned GRAVITY      = 1,
  parameter int unsigned KB_SPEED     = 3,
  parameter int unsigned KB_FRAMES    = 8,
  parameter int unsigned BODY_GAP     = 32
) (
  input logic            clk,
  input logic            reset,
  fighter_motion_if.slave bus
);
  localparam int unsigned SW  = POS_WIDTH + 2;
  localparam int unsigned KbW = $clog2(KB_FRAMES + 1);
  typedef logic signed [SW-1:0] sval_t;

  localparam sval_t WalkV   = sval_t'(WALK_SPEED);
  localparam sval_t JumpV   = sval_t'(JUMP_VEL);
  localparam sval_t GravV   = sval_t'(GRAVITY);
  localparam sval_t KbV     = sval_t'(KB_SPEED);
  localparam sval_t GapV    = sval_t'(BODY_GAP);
  localparam sval_t GroundV = sval_t'(GROUND_Y);
  localparam sval_t MinV    = sval_t'(MIN_X);
  localparam sval_t MaxV    = sval_t'(MAX_X);

  fighter_state_e       state_q, state_d;
  logic [POS_WIDTH-1:0] x_q, x_d, y_q, y_d;
  sval_t                vx_q, vx_d, vy_q, vy_d;
  logic [KbW-1:0]       kb_q, kb_d;
  logic                 face_q, face_d, active_q, active_d, landed_q, landed_d;

  sval_t x_s, y_s, opp_s, walk_vx, hit_vx, walk_c, gap_diff, gap_abs;
  sval_t x_step, vy_eff, y_cand, vy_arc, x_cand, x_clamp;
  logic  toward, gap_block, do_arc, touchdown, wall;
  logic [POS_WIDTH-1:0] y_next;

  assign x_s    = $signed({2'b00, x_q});
  assign y_s    = $signed({2'b00, y_q});
  assign opp_s  = $signed({2'b00, bus.opponent_x});
  assign hit_vx = bus.hit_from_right ? -KbV : KbV;

  // Walk step and whether it would close the gap to the opponent too far.
  always_comb begin
    walk_vx = '0;
    toward  = 1'b0;
    if (bus.move_right && !bus.move_left) begin
      walk_vx = WalkV;
      toward  = bus.opponent_x > x_q;
    end else if (bus.move_left && !bus.move_right) begin
      walk_vx = -WalkV;
      toward  = bus.opponent_x < x_q;
    end
    walk_c    = x_s + walk_vx;
    gap_diff  = walk_c - opp_s;
    gap_abs   = gap_diff[SW-1] ? -gap_diff : gap_diff;
    gap_block = toward && (gap_abs < GapV);
  end

  always_comb begin
    x_step = '0;
    vy_eff = vy_q;
    do_arc = 1'b0;
    unique case (state_q)
      StGround: begin
        if (!bus.hit && bus.move_enable) begin
          if (bus.jump) begin
            x_step = walk_vx;
            vy_eff = -JumpV;
            do_arc = 1'b1;
          end else if (!gap_block) begin
            x_step = walk_vx;
          end
        end
      end
      StAir: begin
        x_step = vx_q;
        do_arc = 1'b1;
      end
      StKnock: begin
        x_step = vx_q;
        do_arc = y_q < POS_WIDTH'(GROUND_Y);
      end
      default: ;
    endcase

    y_cand    = y_s + vy_eff;
    touchdown = do_arc && (y_cand >= GroundV);
    if (!do_arc) begin
      y_next = y_q;
      vy_arc = vy_q;
    end else if (touchdown) begin
      y_next = POS_WIDTH'(GROUND_Y);
      vy_arc = '0;
    end else begin
      y_next = y_cand[POS_WIDTH-1:0];
      vy_arc = vy_eff + GravV;
    end
  end

  assign x_cand = x_s + x_step;

  axis_clamp #(
    .W (SW)
  ) u_clamp_x (
    .val_i      (x_cand),
    .lo_i       (MinV),
    .hi_i       (MaxV),
    .val_o      (x_clamp),
    .hit_wall_o (wall)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    kb_d     = kb_q;
    face_d   = face_q;
    active_d = active_q;
    landed_d = 1'b0;
    if (bus.SCEN) begin
      x_d      = x_clamp[POS_WIDTH-1:0];
      y_d      = y_next;
      vy_d     = vy_arc;
      landed_d = touchdown;
      active_d = (x_d != x_q) || (y_d != y_q);
      if (wall && state_q != StGround) vx_d = '0;
      unique case (state_q)
        StGround: begin
          if (x_q < bus.opponent_x)      face_d = 1'b1;
          else if (x_q > bus.opponent_x) face_d = 1'b0;
          if (bus.hit) begin
            state_d = StKnock;
            kb_d    = KbW'(KB_FRAMES);
            vx_d    = hit_vx;
          end else if (bus.move_enable && bus.jump) begin
            state_d = touchdown ? StGround : StAir;
            vx_d    = (wall || touchdown) ? '0 : walk_vx;
          end
        end
        StAir: begin
          if (touchdown) begin
            state_d = StGround;
            vx_d    = '0;
          end
          if (bus.hit) begin
            state_d = StKnock;
            kb_d    = KbW'(KB_FRAMES);
            vx_d    = hit_vx;
          end
        end
        StKnock: begin
          if (bus.hit) begin
            kb_d = KbW'(KB_FRAMES);
            vx_d = hit_vx;
          end else if (kb_q <= KbW'(1)) begin
            kb_d    = '0;
            vx_d    = '0;
            state_d = (y_next == POS_WIDTH'(GROUND_Y)) ? StGround : StAir;
          end else begin
            kb_d = kb_q - KbW'(1);
          end
        end
        default: state_d = StGround;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StGround;
      x_q      <= POS_WIDTH'(START_X);
      y_q      <= POS_WIDTH'(GROUND_Y);
      vx_q     <= '0;
      vy_q     <= '0;
      kb_q     <= '0;
      face_q   <= START_FACE_R;
      active_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      kb_q     <= kb_d;
      face_q   <= face_d;
      active_q <= active_d;
      landed_q <= landed_d;
    end
  end

  assign bus.pos_x        = x_q;
  assign bus.pos_y        = y_q;
  assign bus.facing_right = face_q;
  assign bus.state        = state_q;
  assign bus.move_active  = active_q;
  assign bus.landed       = landed_q;

endmodule

// File: doc/fighter_motion.md
# fighter_motion

Per-frame position controller for one fighter. On each scene-enable tick it advances walking, a gravity-based jump, or a hit knockback, clamped to the arena walls and to a minimum body gap from the opponent. It drives the sprite renderer and the hit detector and takes intent from the input/attack controller. Every motion constant is a parameter, so the same block serves both players and either arena size.

## Interface
- POS_WIDTH, 10: width of pos_x/pos_y and opponent_x (unsigned pixels).
- GROUND_Y, 400: standing y; y grows downward.
- START_X, 80: pos_x after reset.
- START_FACE_R, 1: facing_right after reset.
- MIN_X / MAX_X, 40 / 600: inclusive horizontal limits.
- WALK_SPEED, 2: px/frame while walking; also the jump's horizontal speed.
- JUMP_VEL, 7: initial upward speed (px/frame).
- GRAVITY, 1: vy increment per frame.
- KB_SPEED / KB_FRAMES, 3 / 8: knockback speed and duration.
- BODY_GAP, 32: minimum |pos_x − opponent_x| allowed when walking toward the opponent.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- SCEN  in  1  one-cycle frame tick; all motion advances only on it.
- move_enable  in  1  0 = ignore walk/jump intent (gravity and knockback still run).
- move_left / move_right / jump  in  1 each  intent levels, sampled on SCEN.
- hit  in  1  knockback request, sampled on SCEN.
- hit_from_right  in  1  1 = push toward −x.
- opponent_x  in  POS_WIDTH  opponent position.
- pos_x / pos_y  out  POS_WIDTH  registered position.
- facing_right  out  1  registered facing.
- state  out  2  GROUND=0, AIR=1, KNOCK=2.
- move_active  out  1  1 for the frame in which x or y changed.
- landed  out  1  one-cycle pulse in the cycle after landing.

## Operation
- Reset values: pos_x=START_X, pos_y=GROUND_Y, facing_right=START_FACE_R, state=GROUND, move_active=0, landed=0. Internal registers are cleared: vx=0, vy=0, kb_cnt=0.
- Internal registers: vx and vy, both signed, POS_WIDTH+2 bits; kb_cnt, $clog2(KB_FRAMES+1) bits.
- GROUND state: evaluated in this priority order.
  - hit → KNOCK. Set kb_cnt=KB_FRAMES and vx=±KB_SPEED; the sign is −KB_SPEED when hit_from_right=1.
  - move_enable && jump → AIR. Set vy=−JUMP_VEL and vx=(right^left) ? ±WALK_SPEED : 0. The first arc step is applied on this same frame.
  - move_enable and exactly one of left/right → x ± WALK_SPEED. The step is suppressed (x unchanged) if the resulting gap to the opponent would fall below BODY_GAP while moving toward the opponent. Moving away is never blocked.
  - Both left and right held, or neither → no motion.
- AIR state: x += vx, y += vy, then vy += GRAVITY.
  - Landing: if y+vy ≥ GROUND_Y, force y=GROUND_Y, vy=0, vx=0, go to GROUND, and pulse landed.
  - Walk/jump intent is ignored in the air.
  - A hit in the air: vx=±KB_SPEED and go to KNOCK, with y continuing under gravity.
- KNOCK state: x += vx, with the vertical arc still applied while y < GROUND_Y. kb_cnt decrements each frame.
  - Exit when kb_cnt reaches 0: to GROUND if y==GROUND_Y, else to AIR with vx=0.
  - A new hit reloads kb_cnt and vx.
- Clamp: the candidate x is computed signed at POS_WIDTH+2 bits and clamped to [MIN_X, MAX_X] before it is registered, so the register never holds an out-of-range value. Clamping in AIR or KNOCK also zeroes vx (wall stop).
- Facing: updated only in GROUND, to facing_right = (pos_x < opponent_x). On equal x it holds its previous value. It is frozen in AIR and KNOCK.
- move_active = (next pos ≠ current pos), registered alongside the position.

## Timing
- Every output updates on the clk edge on which SCEN=1 and holds between ticks.
- Latency is one cycle: intent sampled with SCEN is visible on the next edge.
- landed is high for exactly the one clk cycle after the landing edge, not for a whole frame.
- Reference arc with defaults: airtime is 15 ticks; apex y=372 after ticks 7 and 8; y returns to 400 on tick 15.
- Reset asserted mid-jump or mid-knockback restores all reset values immediately (asynchronous); nothing resumes after release.
- SCEN pulses on back-to-back cycles are legal; each one advances one frame.

## Structure
- Shared package fighter_pkg holds:
  - the state encoding (GROUND/AIR/KNOCK), reused by the attack FSM and the renderer;
  - the default arena constants MIN_X, MAX_X, GROUND_Y.
- Sub-module axis_clamp: combinational. It takes a signed candidate plus limits and returns the clamped value and a hit_wall flag; it is instantiated for x.

## Test plan
- Reset, then 10 ticks with move_right, opponent at 500 → pos_x 80→100, move_active=1, facing_right=1.
- Jump with no direction from x=200 → y sequence 393,387,382,378,375,373,372,372,373,…,400; landed pulses once after tick 15; pos_x stays 200.
- Right jump from x=596 → x clamps at 600 on tick 2, vx becomes 0, and the jump still lands at y=400 on tick 15.
- Walk right at x=460, opponent at 500 → x reaches 468 and then stays 468 (gap 32); holding left moves it to 466.
- hit with hit_from_right=1 at x=300 on ground → x decreases by 3 per tick for 8 ticks to 276, then state=GROUND; move/jump intent is ignored meanwhile.
- Assert reset during tick 5 of a jump → pos_y=400, state=GROUND, landed=0 within the same cycle.
